// File: rtl/fix_acc_drain.sv
// Readout sweep for the accumulator buffer: streams entries 0..DEPTH-1, each value
// taken from the dirty cache register, zero (never written) or the buffer RAM.
module fix_acc_drain #(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 128,
  parameter int RD_LATENCY = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  input  logic [DEPTH-1:0]      w_map,
  input  logic                  cache_dirty,
  input  logic [AW-1:0]         cache_addr,
  input  logic [DATA_WIDTH-1:0] cache_data,
  output logic                  mem_rd_en,
  output logic [AW-1:0]         mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [AW-1:0]         m_index,
  output logic                  m_last
);
  localparam int CW = $clog2(RD_LATENCY) + 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CW-1:0] LAT_LOAD = CW'(RD_LATENCY - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RD, S_WAIT, S_OUT} state_t;

  state_t                r_state;
  logic [AW-1:0]         r_idx;
  logic [CW-1:0]         r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_mem_rd_en;
  logic [AW-1:0]         r_mem_addr;
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic [AW-1:0]         r_m_index;
  logic                  r_m_last;

  logic w_cache_hit;
  logic w_written;

  assign w_cache_hit = cache_dirty && (cache_addr == r_idx);
  assign w_written   = w_map[r_idx];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_mem_addr  <= '0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_index   <= '0;
      r_m_last    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Abort drops any read still in flight simply by leaving WAIT without capturing.
      if (abort) begin
        r_state     <= S_IDLE;
        r_busy      <= 1'b0;
        r_m_valid   <= 1'b0;
        r_mem_rd_en <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_idx   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            r_m_index <= r_idx;
            r_m_last  <= (r_idx == LAST_IDX);
            if (w_cache_hit) begin
              r_m_data  <= cache_data;
              r_m_valid <= 1'b1;
              r_state   <= S_OUT;
            end else if (!w_written) begin
              r_m_data  <= '0;
              r_m_valid <= 1'b1;
              r_state   <= S_OUT;
            end else begin
              r_mem_rd_en <= 1'b1;
              r_mem_addr  <= r_idx;
              r_state     <= S_RD;
            end
          end
          S_RD: begin
            r_mem_rd_en <= 1'b0;
            r_cnt       <= LAT_LOAD;
            r_state     <= S_WAIT;
          end
          // A zero load (RD_LATENCY==1) captures in the first WAIT cycle, i.e. one edge after RD.
          S_WAIT: begin
            if (r_cnt == '0) begin
              r_m_data  <= mem_rd_data;
              r_m_valid <= 1'b1;
              r_state   <= S_OUT;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          S_OUT: begin
            if (m_ready) begin
              r_m_valid <= 1'b0;
              if (r_m_last) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_idx   <= r_idx + 1'b1;
                r_state <= S_ISSUE;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_rd_en = r_mem_rd_en;
  assign mem_addr  = r_mem_addr;
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign m_index   = r_m_index;
  assign m_last    = r_m_last;

endmodule

// File: tb/tb_fix_acc_drain.sv
// Bench for fix_acc_drain: table-driven sweeps, hand-written corner sequences and
// randomized sweeps checked against a per-entry source-priority model.
module tb_fix_acc_drain;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int RDL   = 2;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rstn, start, abort;
  logic          busy, done;
  logic [3:0]    w_map;
  logic          cache_dirty;
  logic [AW-1:0] cache_addr;
  logic [DW-1:0] cache_data;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_index;

  fix_acc_drain #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .RD_LATENCY(RDL)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .busy(busy), .done(done),
    .w_map(w_map), .cache_dirty(cache_dirty), .cache_addr(cache_addr),
    .cache_data(cache_data), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_index(m_index), .m_last(m_last)
  );

  always #5 clk = ~clk;

  // RAM model: address sampled on the rd_en edge, data presented RDL edges later.
  logic [3:0][DW-1:0] mem_arr;
  logic [DW-1:0] pipe [RDL];
  always @(posedge clk) begin
    pipe[0] <= mem_rd_en ? mem_arr[mem_addr] : 32'hFFFF_FFFF;
    for (int i = 1; i < RDL; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rd_data = pipe[RDL-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         beats[$];
  logic [AW-1:0] rd_q[$];
  int            vrise_q[$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  logic          done_busy = 1'b0;
  logic          prev_v = 1'b0;

  always @(negedge clk) begin
    if (rstn) begin
      if (m_valid && m_ready) beats.push_back({m_index, m_last, m_data});
      if (m_valid && !prev_v) vrise_q.push_back(cyc);
      if (mem_rd_en) rd_q.push_back(mem_addr);
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_busy = busy;
      end
      prev_v = m_valid;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_sweep(input string tag, input logic [3:0] wm, input logic cd,
                           input logic [AW-1:0] ca, input logic [DW-1:0] cdat,
                           input logic [3:0][DW-1:0] mm, input logic [3:0][DW-1:0] exp_data,
                           input logic [3:0] exp_reads, input int exp_dur, input int exp_first,
                           input int mode, input int mid_start);
    int b0, rc0, dc0, v0, s, n, stall;
    logic [3:0] rmask;
    beat_t snap;
    w_map = wm; cache_dirty = cd; cache_addr = ca; cache_data = cdat; mem_arr = mm;
    m_ready = 1'b1;
    b0 = beats.size(); rc0 = rd_q.size(); dc0 = done_cnt; v0 = vrise_q.size();
    stall = 0; snap = '0;
    start = 1'b1; s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_s1"}, 64'(busy), 64'd1);
    n = 0;
    while (done_cnt == dc0 && n < 400) begin
      start = (n == mid_start);
      if (mode == 2 && m_valid && m_index == 2'd1 && stall < 3) begin
        if (stall == 0) snap = {m_index, m_last, m_data};
        else chk({tag, "_stall_hold"}, 64'({m_index, m_last, m_data}), 64'(snap));
        m_ready = 1'b0;
        stall++;
      end else begin
        m_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_done_seen"}, 64'(done_cnt > dc0), 64'd1);
    chk({tag, "_done_once"}, 64'(done_cnt - dc0), 64'd1);
    chk({tag, "_busy_at_done"}, 64'(done_busy), 64'd0);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    chk({tag, "_beats"}, 64'(beats.size() - b0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (b0 + i < beats.size()) begin
        chk($sformatf("%s_b%0d_idx", tag, i), 64'(beats[b0+i].idx), 64'(i));
        chk($sformatf("%s_b%0d_last", tag, i), 64'(beats[b0+i].last), 64'(i == 3));
        chk($sformatf("%s_b%0d_data", tag, i), 64'(beats[b0+i].data), 64'(exp_data[i]));
      end
    end
    rmask = '0;
    for (int i = rc0; i < rd_q.size(); i++) rmask[rd_q[i]] = 1'b1;
    chk({tag, "_read_map"}, 64'(rmask), 64'(exp_reads));
    chk({tag, "_read_cnt"}, 64'(rd_q.size() - rc0), 64'($countones(exp_reads)));
    if (mode == 2) chk({tag, "_stall_cycles"}, 64'(stall), 64'd3);
    if (exp_dur >= 0) chk({tag, "_done_cycle"}, 64'(done_cyc - s), 64'(exp_dur));
    if (exp_first >= 0 && vrise_q.size() > v0)
      chk({tag, "_first_valid"}, 64'(vrise_q[v0] - s), 64'(exp_first));
  endtask

  typedef struct {
    logic [3:0]         wmap;
    logic               cd;
    logic [AW-1:0]      ca;
    logic [DW-1:0]      cdata;
    logic [3:0][DW-1:0] mem;
    logic [3:0][DW-1:0] exp_data;
    logic [3:0]         exp_reads;
    int                 exp_dur;
    int                 exp_first;
  } vec_t;

  vec_t vecs[5];
  logic [3:0][DW-1:0] base_mem;

  initial begin
    rstn = 1'b0; start = 1'b1; abort = 1'b0; m_ready = 1'b1;
    w_map = '0; cache_dirty = 1'b0; cache_addr = '0; cache_data = '0;
    base_mem = {32'h13, 32'h12, 32'h11, 32'h10};
    mem_arr = base_mem;

    vecs[0] = '{4'b1111, 1'b0, 2'd0, 32'h0, base_mem,
                {32'h13, 32'h12, 32'h11, 32'h10}, 4'b1111, 21, 5};
    vecs[1] = '{4'b0101, 1'b0, 2'd0, 32'h0, base_mem,
                {32'h0, 32'h12, 32'h0, 32'h10}, 4'b0101, 15, 5};
    vecs[2] = '{4'b1111, 1'b1, 2'd2, 32'hDEAD, {32'h13, 32'hBEEF, 32'h11, 32'h10},
                {32'h13, 32'hDEAD, 32'h11, 32'h10}, 4'b1011, 18, 5};
    vecs[3] = '{4'b0000, 1'b1, 2'd0, 32'h55, base_mem,
                {32'h0, 32'h0, 32'h0, 32'h55}, 4'b0000, 9, 2};
    vecs[4] = '{4'b1010, 1'b1, 2'd3, 32'hAAAA, base_mem,
                {32'hAAAA, 32'h0, 32'h11, 32'h0}, 4'b0010, 12, 2};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_index", 64'(m_index), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    start = 1'b0; rstn = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++)
      run_sweep($sformatf("vec%0d", v), vecs[v].wmap, vecs[v].cd, vecs[v].ca, vecs[v].cdata,
                vecs[v].mem, vecs[v].exp_data, vecs[v].exp_reads, vecs[v].exp_dur,
                vecs[v].exp_first, 0, -1);

    // Backpressure on beat 1 for three cycles.
    run_sweep("stall", 4'b1111, 1'b0, 2'd0, 32'h0, base_mem, vecs[0].exp_data, 4'b1111,
              24, 5, 2, -1);

    // A second start mid-sweep must not disturb it.
    run_sweep("midstart", 4'b1111, 1'b0, 2'd0, 32'h0, base_mem, vecs[0].exp_data, 4'b1111,
              21, 5, 0, 4);

    // Abort while waiting on the RAM read for index 2.
    begin
      int b0, dc0, n;
      w_map = 4'b1111; cache_dirty = 1'b0; mem_arr = base_mem; m_ready = 1'b1;
      b0 = beats.size(); dc0 = done_cnt;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!(mem_rd_en && mem_addr == 2'd2) && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      chk("abort_reached_rd2", 64'(n < 100), 64'd1);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_m_valid", 64'(m_valid), 64'd0);
      chk("abort_mem_rd_en", 64'(mem_rd_en), 64'd0);
      repeat (10) @(posedge clk);
      #1;
      chk("abort_no_done", 64'(done_cnt - dc0), 64'd0);
      chk("abort_beats", 64'(beats.size() - b0), 64'd2);
      chk("abort_m_valid_later", 64'(m_valid), 64'd0);
    end
    run_sweep("restart", 4'b1111, 1'b0, 2'd0, 32'h0, base_mem, vecs[0].exp_data, 4'b1111,
              21, 5, 0, -1);

    // start and abort together while idle.
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("sa_busy_later", 64'(busy), 64'd0);
    chk("sa_rd_en", 64'(mem_rd_en), 64'd0);

    // Randomized sweeps against the source-priority model.
    for (int k = 0; k < 20; k++) begin
      logic [3:0] wm, er;
      logic cdd;
      logic [AW-1:0] caa;
      logic [DW-1:0] cdt;
      logic [3:0][DW-1:0] mm, ed;
      int md, dur;
      wm = 4'($urandom); cdd = 1'($urandom); caa = 2'($urandom); cdt = $urandom;
      for (int j = 0; j < 4; j++) mm[j] = $urandom;
      md = k % 2; dur = 1; er = '0;
      for (int j = 0; j < 4; j++) begin
        if (cdd && caa == 2'(j)) ed[j] = cdt;
        else if (!wm[j]) ed[j] = '0;
        else begin
          ed[j] = mm[j];
          er[j] = 1'b1;
        end
        dur += er[j] ? (3 + RDL) : 2;
      end
      run_sweep($sformatf("rnd%0d", k), wm, cdd, caa, cdt, mm, ed, er,
                (md == 0) ? dur : -1, -1, md, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fix_acc_drain.md
# fix_acc_drain

Readout engine for the fixed-point accumulator buffer. After accumulation finishes, it sweeps every entry 0..DEPTH-1 and emits each value on a valid/ready output stream. Each value comes from one of three sources, in priority order: the accumulator's dirty single-entry register cache, zero for never-written entries, or the backing buffer RAM. It sits downstream of the accumulator cache and shares its buffer RAM read port.

## Interface
Parameters:
- DEPTH, 32, number of accumulator entries.
- DATA_WIDTH, 128, entry width in bits.
- RD_LATENCY, 2, buffer RAM read latency in cycles (≥1).
- AW (localparam), clog2(DEPTH), address/index width.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- abort  in  1  terminates a sweep; no done pulse.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse after the final beat is transferred.
- w_map  in  DEPTH  bit i = 1 means entry i was ever written.
- cache_dirty  in  1  the accumulator cache register holds newer data than the RAM.
- cache_addr  in  AW  entry index held by the cache register.
- cache_data  in  DATA_WIDTH  cache register contents.
- mem_rd_en  out  1  RAM read strobe (registered).
- mem_addr  out  AW  RAM read address (registered).
- mem_rd_data  in  DATA_WIDTH  RAM read data.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_WIDTH  entry value.
- m_index  out  AW  entry index.
- m_last  out  1  high on the beat for index DEPTH-1.

## Operation
- States: IDLE, ISSUE, RD, WAIT, OUT.
- IDLE:
  - start=1 and abort=0: idx←0, busy←1, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: the source is chosen from the inputs sampled in this cycle.
  - If cache_dirty && cache_addr==idx: m_data←cache_data, go to OUT.
  - Else if w_map[idx]==0: m_data←0, go to OUT.
  - Else: mem_rd_en←1, mem_addr←idx, go to RD.
- RD: mem_rd_en is high for this cycle only. Load the latency counter with RD_LATENCY-1, go to WAIT.
  - If RD_LATENCY==1, skip WAIT: m_data←mem_rd_data at the end of the cycle following RD, go to OUT.
- WAIT: decrement the counter. When it reaches 0, m_data←mem_rd_data, go to OUT.
- OUT:
  - m_valid=1, m_index=idx, m_last=(idx==DEPTH-1).
  - On m_valid&&m_ready:
    - If m_last: go to IDLE, busy←0, done←1 for one cycle.
    - Else: idx←idx+1, go to ISSUE.
- abort=1 in any state:
  - Next cycle: IDLE, busy=0, m_valid=0, mem_rd_en=0, no done pulse.
  - Any RAM data still in flight is discarded.
- start while busy is ignored.
- start and abort in the same cycle: abort wins.
- rstn=0 has priority over everything. It takes effect at the next edge regardless of state.
- The upstream accumulator must not change the RAM or cache contents during a sweep. The inputs are sampled only in ISSUE and at the data-capture edge.
- Exactly one RAM read is issued per written, non-cache-hit entry. None is issued otherwise.
- idx never wraps. The sweep ends after index DEPTH-1.

## Timing
- Reset values: busy=0, done=0, m_valid=0, m_data=0, m_index=0, m_last=0, mem_rd_en=0, mem_addr=0; state IDLE.
- Let start be sampled at the edge ending cycle s. Then ISSUE for index 0 is cycle s+1, and busy=1 from cycle s+1.
- Let ISSUE be cycle c.
  - Cache or zero source: m_valid=1 in cycle c+1.
  - RAM source: mem_rd_en=1 in cycle c+1; m_valid=1 in cycle c+2+RD_LATENCY.
- The RAM samples mem_addr at the edge ending the mem_rd_en cycle. mem_rd_data is captured RD_LATENCY edges later.
- While m_valid&&!m_ready: m_data, m_index and m_last are held stable and no RAM read is issued.
- After a transfer, m_valid=0 for at least one cycle (the ISSUE bubble). Peak throughput is one beat per 2 cycles.
- done is high in the cycle after the final transfer edge, and busy is 0 in that same cycle. A start in the done cycle is accepted.

## Test plan
- DEPTH=4, RD_LATENCY=2, w_map=4'b1111, cache_dirty=0, mem={0x10,0x11,0x12,0x13}, m_ready=1, start sampled at cycle s:
  - First m_valid in cycle s+5.
  - Beats carry index 0..3 with data 0x10..0x13; m_last only on index 3.
  - done pulses once; exactly 4 mem_rd_en cycles.
- w_map=4'b0101: indices 1 and 3 emit 0 with m_valid at ISSUE+1; mem_rd_en is never asserted with mem_addr 1 or 3.
- cache_dirty=1, cache_addr=2, cache_data=0xDEAD, mem[2]=0xBEEF: beat 2 carries 0xDEAD, and no RAM read is made to address 2.
- m_ready=0 for 3 cycles while beat 1 is valid: m_data, m_index and m_last are stable, no additional mem_rd_en pulses, and the sweep completes with correct data.
- abort in WAIT for index 2: next cycle busy=0, m_valid=0, and done is never pulsed. A new start then restarts at index 0 and completes all 4 beats.
- start pulsed mid-sweep: no effect. start and abort in the same cycle while idle: busy stays 0.
